nq_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the NanoQuarter core. Steps each 16-bit instruction through fetch, decode, execute, memory and writeback. Drives the ALU's `{op, funct}` select, the register-file/PC/IR write enables and the single-port memory request handshake. It sits between the instruction register and the shared datapath, and is the only block that asserts memory requests.

---
 rtl/nq_ctrl_fsm_pkg.sv | 53 +++++
 rtl/nq_ctrl_fsm_inst_decode.sv | 49 ++++
 rtl/nq_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_nq_ctrl_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nq_ctrl_fsm_pkg.sv
// Shared definitions for the NanoQuarter control sequencer: op/funct codes,
// instruction field positions, FSM state and instruction class encodings.
package nq_ctrl_fsm_pkg;

  localparam logic [1:0] OP_RTYPE  = 2'b00;
  localparam logic [1:0] OP_ITYPE  = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_HALT   = 2'b11;

  // I-type funct codes, shared with the ALU
  localparam logic [2:0] FN_LUI = 3'b000;
  localparam logic [2:0] FN_LBI = 3'b001;
  localparam logic [2:0] FN_SUI = 3'b010;
  localparam logic [2:0] FN_SBI = 3'b011;
  localparam logic [2:0] FN_LW  = 3'b100;
  localparam logic [2:0] FN_SW  = 3'b101;

  localparam logic [2:0] FN_RTYPE_MAX = 3'b110;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 14;
  localparam int unsigned IFN_HI = 13;
  localparam int unsigned IFN_LO = 11;
  localparam int unsigned RFN_HI = 4;
  localparam int unsigned RFN_LO = 2;

  localparam int unsigned TMO_W = 4;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE     = 3'd0,
    CL_ITYPE_ALU = 3'd1,
    CL_LOAD      = 3'd2,
    CL_STORE     = 3'd3,
    CL_BRANCH    = 3'd4,
    CL_HALT      = 3'd5,
    CL_ILLEGAL   = 3'd6
  } inst_class_e;

  function automatic logic class_uses_mem(input inst_class_e c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/nq_ctrl_fsm_inst_decode.sv
// Combinational instruction classifier: maps the IR to an execution class
// and the {op, funct} select presented to the ALU.
module nq_inst_decode
  import nq_ctrl_fsm_pkg::*;
(
  input  logic [15:0]  inst,
  output inst_class_e  cls,
  output logic [1:0]   alu_op,
  output logic [2:0]   alu_funct
);

  logic [1:0] op;
  logic [2:0] rfn;
  logic [2:0] ifn;
  logic       unused_bits;

  assign op  = inst[OP_HI:OP_LO];
  assign rfn = inst[RFN_HI:RFN_LO];
  assign ifn = inst[IFN_HI:IFN_LO];
  assign unused_bits = ^{inst[10:5], inst[1:0]};

  always_comb begin
    cls       = CL_ILLEGAL;
    alu_op    = op;
    alu_funct = '0;
    unique case (op)
      OP_RTYPE: begin
        alu_funct = rfn;
        if (rfn <= FN_RTYPE_MAX) cls = CL_RTYPE;
      end
      OP_ITYPE: begin
        alu_funct = ifn;
        case (ifn)
          FN_LUI, FN_LBI:        cls = CL_ITYPE_ALU;
          FN_LW:                 cls = CL_LOAD;
          FN_SUI, FN_SBI, FN_SW: cls = CL_STORE;
          default:               cls = CL_ILLEGAL;
        endcase
      end
      OP_BRANCH: begin
        alu_funct = ifn;
        cls       = CL_BRANCH;
      end
      OP_HALT: cls = CL_HALT;
      default: cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/nq_ctrl_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the NanoQuarter
// core, with a memory-handshake timeout that latches bus_err and halts.
module nq_ctrl_fsm
  import nq_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic [1:0]  alu_op,
  output logic [2:0]  alu_funct,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e            state, state_n;
  inst_class_e       dec_cls, cls_q;
  logic [1:0]        dec_op, op_q;
  logic [2:0]        dec_funct, funct_q;
  logic [TMO_W-1:0]  wait_cnt;
  logic              bus_err_q;
  logic              timeout;

  nq_inst_decode u_dec (
    .inst      (inst),
    .cls       (dec_cls),
    .alu_op    (dec_op),
    .alu_funct (dec_funct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
      cls_q     <= CL_ILLEGAL;
      op_q      <= '0;
      funct_q   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
      // ALU select is captured at DECODE so it holds through MEM/WB
      // independent of later IR activity.
      if (state == ST_DECODE) begin
        cls_q   <= dec_cls;
        op_q    <= dec_op;
        funct_q <= dec_funct;
      end
    end
  end

  always_comb begin
    state_n      = state;
    timeout      = 1'b0;
    alu_op       = '0;
    alu_funct    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    unique case (state)
      ST_BOOT: state_n = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = ST_DECODE;
        end else if (wait_cnt == TMO_LAST) begin
          timeout = 1'b1;
          state_n = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CL_ILLEGAL: begin
            illegal = 1'b1;
            state_n = ST_FETCH;
          end
          CL_HALT: state_n = ST_HALT;
          default: state_n = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_op    = op_q;
        alu_funct = funct_q;
        if (cls_q == CL_BRANCH) begin
          pc_sel  = 1'b1;
          pc_we   = br_taken;
          state_n = ST_FETCH;
        end else if (class_uses_mem(cls_q)) begin
          state_n = ST_MEM;
        end else begin
          state_n = ST_WB;
        end
      end
      ST_MEM: begin
        alu_op       = op_q;
        alu_funct    = funct_q;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CL_STORE);
        if (mem_ack) begin
          state_n = (cls_q == CL_LOAD) ? ST_WB : ST_FETCH;
        end else if (wait_cnt == TMO_LAST) begin
          timeout = 1'b1;
          state_n = ST_HALT;
        end
      end
      ST_WB: begin
        alu_op    = op_q;
        alu_funct = funct_q;
        rf_we     = 1'b1;
        wb_sel    = (cls_q == CL_LOAD);
        state_n   = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_n = ST_BOOT;
    endcase
  end

  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_nq_ctrl_fsm.sv
// Directed cycle-by-cycle bench for nq_ctrl_fsm: each step queues the
// expected output vector, then pops and compares it against the DUT.
module tb_nq_ctrl_fsm;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] alu_funct;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       rf_we;
    logic       wb_sel;
    logic       illegal;
    logic       bus_err;
    logic       halted;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst;
  logic        mem_ack;
  logic        br_taken;
  logic [1:0]  alu_op;
  logic [2:0]  alu_funct;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
  logic        rf_we, wb_sel, illegal, bus_err, halted;

  outs_t obs;
  outs_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  nq_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .mem_ack      (mem_ack),
    .br_taken     (br_taken),
    .alu_op       (alu_op),
    .alu_funct    (alu_funct),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  assign obs = {alu_op, alu_funct, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                pc_sel, rf_we, wb_sel, illegal, bus_err, halted};

  // Flags: R req, W we, A addr_sel, I ir_we, P pc_we, S pc_sel, F rf_we,
  // B wb_sel, X illegal, E bus_err, H halted
  function automatic outs_t ex(input logic [1:0] op, input logic [2:0] fn, input string fl);
    outs_t r = '0;
    r.alu_op    = op;
    r.alu_funct = fn;
    for (int i = 0; i < fl.len(); i++) begin
      case (fl[i])
        "R": r.mem_req      = 1'b1;
        "W": r.mem_we       = 1'b1;
        "A": r.mem_addr_sel = 1'b1;
        "I": r.ir_we        = 1'b1;
        "P": r.pc_we        = 1'b1;
        "S": r.pc_sel       = 1'b1;
        "F": r.rf_we        = 1'b1;
        "B": r.wb_sel       = 1'b1;
        "X": r.illegal      = 1'b1;
        "E": r.bus_err      = 1'b1;
        "H": r.halted       = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic check_now();
    outs_t e;
    string t;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard: observed empty queue required an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) passes++;
      else $error("FAIL %s: observed %b required %b", t, obs, e);
    end
  endtask

  task automatic cyc(input logic ack, input logic br, input outs_t e, input string t);
    @(negedge clk);
    mem_ack  = ack;
    br_taken = br;
    exp_q.push_back(e);
    tag_q.push_back(t);
    check_now();
  endtask

  // Reset asserted at a falling edge, held across rising edges, then released;
  // the BOOT cycle is checked right after release.
  task automatic sync_reset(input string t);
    @(negedge clk);
    mem_ack  = 1'b0;
    br_taken = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back('0);
    tag_q.push_back({t, "_held"});
    check_now();
    rst_n = 1'b1;
    exp_q.push_back('0);
    tag_q.push_back({t, "_boot"});
    check_now();
  endtask

  initial begin
    rst_n    = 1'b0;
    inst     = '0;
    mem_ack  = 1'b0;
    br_taken = 1'b0;
    repeat (2) @(posedge clk);
    sync_reset("rst0");

    // ADD, zero-wait fetch
    inst = {2'b00, 9'b0, 3'b101, 2'b00};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "add_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "add_d");
    cyc(0, 0, ex(2'b00, 3'b101, ""),    "add_e");
    cyc(0, 0, ex(2'b00, 3'b101, "F"),   "add_w");

    // LW, memory ack delayed 3 cycles
    inst = {2'b01, 3'b100, 11'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "lw_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "lw_d");
    cyc(0, 0, ex(2'b01, 3'b100, ""),    "lw_e");
    cyc(0, 0, ex(2'b01, 3'b100, "RA"),  "lw_m1");
    cyc(0, 0, ex(2'b01, 3'b100, "RA"),  "lw_m2");
    cyc(0, 0, ex(2'b01, 3'b100, "RA"),  "lw_m3");
    cyc(1, 0, ex(2'b01, 3'b100, "RA"),  "lw_m4");
    cyc(0, 0, ex(2'b01, 3'b100, "FB"),  "lw_w");

    // SBI; stray ack in DECODE must be ignored
    inst = {2'b01, 3'b011, 11'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "sbi_f");
    cyc(1, 0, ex(2'b00, 3'b000, ""),    "sbi_d");
    cyc(0, 0, ex(2'b01, 3'b011, ""),    "sbi_e");
    cyc(1, 0, ex(2'b01, 3'b011, "RWA"), "sbi_m");

    // Branch taken, then not taken
    inst = {2'b10, 3'b010, 11'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "bt_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "bt_d");
    cyc(0, 1, ex(2'b10, 3'b010, "PS"),  "bt_e");
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "bn_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "bn_d");
    cyc(0, 0, ex(2'b10, 3'b010, "S"),   "bn_e");

    // Illegal R-type funct 111, then illegal I-type funct 110
    inst = {2'b00, 9'b0, 3'b111, 2'b00};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "ilr_f");
    cyc(0, 0, ex(2'b00, 3'b000, "X"),   "ilr_d");
    inst = {2'b01, 3'b110, 11'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "ili_f");
    cyc(0, 0, ex(2'b00, 3'b000, "X"),   "ili_d");

    // Fetch timeout: 15 unacknowledged request cycles, then sticky halt
    for (int i = 0; i < 15; i++) cyc(0, 0, ex(2'b00, 3'b000, "R"), "tmo_wait");
    cyc(1, 0, ex(2'b00, 3'b000, "EH"), "tmo_halt1");
    cyc(1, 1, ex(2'b00, 3'b000, "EH"), "tmo_halt2");
    cyc(0, 0, ex(2'b00, 3'b000, "EH"), "tmo_halt3");
    sync_reset("rst1");

    // HALT instruction
    inst = {2'b11, 14'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "hlt_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "hlt_d");
    cyc(1, 0, ex(2'b00, 3'b000, "H"),   "hlt_h1");
    cyc(0, 0, ex(2'b00, 3'b000, "H"),   "hlt_h2");
    sync_reset("rst2");

    // Asynchronous reset in the middle of a MEM wait
    inst = {2'b01, 3'b100, 11'b0};
    cyc(1, 0, ex(2'b00, 3'b000, "RIP"), "ar_f");
    cyc(0, 0, ex(2'b00, 3'b000, ""),    "ar_d");
    cyc(0, 0, ex(2'b01, 3'b100, ""),    "ar_e");
    cyc(0, 0, ex(2'b01, 3'b100, "RA"),  "ar_m1");
    cyc(0, 0, ex(2'b01, 3'b100, "RA"),  "ar_m2");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("ar_async");
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('0);
    tag_q.push_back("ar_boot");
    check_now();
    cyc(0, 0, ex(2'b00, 3'b000, "R"), "ar_fetch");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
